// File: rtl/rv_exec_sequencer_if.sv
// Bundle of fetch handshake, register file and ALU signals seen by rv_exec_sequencer.
// slave is the sequencer's view; master is the surrounding pipeline's view.
interface rv_exec_sequencer_if #(
  parameter int COUNT_WIDTH = 32
);
  logic                   instr_valid;
  logic                   instr_ready;
  logic [31:0]            instruction;

  logic [4:0]             rf_rs1;
  logic [4:0]             rf_rs2;
  logic [31:0]            rf_rs1_value;
  logic [31:0]            rf_rs2_value;

  logic [31:0]            alu_instruction;
  logic [31:0]            alu_rs1_value;
  logic [31:0]            alu_rs2_value;
  logic                   alu_enable;
  logic [31:0]            alu_result;

  logic                   rf_we;
  logic [4:0]             rf_rd;
  logic [31:0]            rf_wd;

  logic                   illegal;
  logic                   busy;
  logic [COUNT_WIDTH-1:0] retired_count;

  modport slave (
    input  instr_valid,
    input  instruction,
    input  rf_rs1_value,
    input  rf_rs2_value,
    input  alu_result,
    output instr_ready,
    output rf_rs1,
    output rf_rs2,
    output alu_instruction,
    output alu_rs1_value,
    output alu_rs2_value,
    output alu_enable,
    output rf_we,
    output rf_rd,
    output rf_wd,
    output illegal,
    output busy,
    output retired_count
  );

  modport master (
    output instr_valid,
    output instruction,
    output rf_rs1_value,
    output rf_rs2_value,
    output alu_result,
    input  instr_ready,
    input  rf_rs1,
    input  rf_rs2,
    input  alu_instruction,
    input  alu_rs1_value,
    input  alu_rs2_value,
    input  alu_enable,
    input  rf_we,
    input  rf_rd,
    input  rf_wd,
    input  illegal,
    input  busy,
    input  retired_count
  );
endinterface

// File: rtl/rv_exec_sequencer.sv
// Four-state controller walking one R-type instruction through read, execute and writeback.
// Non-R-type opcodes are rejected in READ with a one-cycle illegal pulse.
module rv_exec_sequencer #(
  parameter logic [6:0] OPCODE_R    = 7'b0110011,
  parameter int         COUNT_WIDTH = 32
) (
  input logic                clock,
  input logic                reset,
  rv_exec_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  state_t                 r_state;
  logic [31:0]            r_instruction;
  logic [31:0]            r_rs1_value;
  logic [31:0]            r_rs2_value;
  logic                   r_illegal;
  logic                   r_alu_enable;
  logic                   r_rf_we;
  logic [COUNT_WIDTH-1:0] r_retired_count;

  logic                   w_accept;
  logic                   w_latched_is_r;
  logic                   w_incoming_is_r;
  logic                   w_rd_nonzero;

  assign w_accept        = bus.instr_valid && (r_state == ST_IDLE);
  assign w_latched_is_r  = (r_instruction[6:0] == OPCODE_R);
  assign w_incoming_is_r = (bus.instruction[6:0] == OPCODE_R);
  assign w_rd_nonzero    = (r_instruction[11:7] != 5'd0);

  // illegal, alu_enable and rf_we are set on the edge entering READ, EXEC and WB
  // so that each is a clean flop output covering exactly that state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_instruction   <= '0;
      r_rs1_value     <= '0;
      r_rs2_value     <= '0;
      r_illegal       <= 1'b0;
      r_alu_enable    <= 1'b0;
      r_rf_we         <= 1'b0;
      r_retired_count <= '0;
    end else begin
      r_illegal    <= 1'b0;
      r_alu_enable <= 1'b0;
      r_rf_we      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_instruction <= bus.instruction;
            r_illegal     <= !w_incoming_is_r;
            r_state       <= ST_READ;
          end
        end
        ST_READ: begin
          if (w_latched_is_r) begin
            r_rs1_value  <= bus.rf_rs1_value;
            r_rs2_value  <= bus.rf_rs2_value;
            r_alu_enable <= 1'b1;
            r_state      <= ST_EXEC;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          // x0 is hardwired, so its write is dropped here while the op still retires.
          r_rf_we <= w_rd_nonzero;
          r_state <= ST_WB;
        end
        ST_WB: begin
          r_retired_count <= r_retired_count + 1'b1;
          r_state         <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.instr_ready     = (r_state == ST_IDLE);
  assign bus.busy            = (r_state != ST_IDLE);
  assign bus.rf_rs1          = r_instruction[19:15];
  assign bus.rf_rs2          = r_instruction[24:20];
  assign bus.alu_instruction = r_instruction;
  assign bus.alu_rs1_value   = r_rs1_value;
  assign bus.alu_rs2_value   = r_rs2_value;
  assign bus.alu_enable      = r_alu_enable;
  assign bus.illegal         = r_illegal;
  assign bus.rf_we           = r_rf_we;
  assign bus.rf_rd           = r_instruction[11:7];
  // The ALU result is registered one cycle after enable, which is exactly WB.
  assign bus.rf_wd           = (r_state == ST_WB) ? bus.alu_result : 32'd0;
  assign bus.retired_count   = r_retired_count;

endmodule

// File: tb/tb_rv_exec_sequencer.sv
// Directed bench for rv_exec_sequencer with a small register file and adder ALU around it.
// A 4-bit retired counter lets the wrap case be reached with a handful of operations.
module tb_rv_exec_sequencer;

  localparam int CW = 4;

  localparam logic [31:0] ADD_X3_X1_X2 = 32'h002081B3;
  localparam logic [31:0] ADD_X4_X3_X3 = 32'h00318233;
  localparam logic [31:0] ADDI_NOP     = 32'h00000013;
  localparam logic [31:0] ADD_X0_X1_X2 = 32'h00208033;
  localparam logic [31:0] ADD_X5_X1_X2 = 32'h002082B3;
  localparam logic [31:0] ADD_X6_X1_X2 = 32'h00208333;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  int   cyc;
  logic [31:0] rfMem [32];

  rv_exec_sequencer_if #(.COUNT_WIDTH(CW)) sIf ();

  rv_exec_sequencer #(
    .OPCODE_R   (7'b0110011),
    .COUNT_WIDTH(CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (sIf.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Register file: combinational reads, write on the clock edge, x0 stays zero.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rfMem[i] <= 32'd0;
      rfMem[1] <= 32'd5;
      rfMem[2] <= 32'd7;
    end else if (sIf.rf_we && (sIf.rf_rd != 5'd0)) begin
      rfMem[sIf.rf_rd] <= sIf.rf_wd;
    end
  end

  assign sIf.rf_rs1_value = rfMem[sIf.rf_rs1];
  assign sIf.rf_rs2_value = rfMem[sIf.rf_rs2];

  // ALU stand-in: registered add, valid the cycle after enable.
  always @(posedge clock or posedge reset) begin
    if (reset) sIf.alu_result <= 32'd0;
    else if (sIf.alu_enable) sIf.alu_result <= sIf.alu_rs1_value + sIf.alu_rs2_value;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Called at a falling edge while idle; runs one legal op through to IDLE again.
  task automatic applyStimulus(input logic [31:0] instr);
    sIf.instr_valid = 1'b1;
    sIf.instruction = instr;
    @(negedge clock);
    sIf.instr_valid = 1'b0;
    sIf.instruction = 32'd0;
    repeat (3) @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  cycRead1;
    int  cycRead2;
    bit  found;

    checks = 0;
    errors = 0;
    cyc    = 0;
    reset  = 1'b1;
    sIf.instr_valid = 1'b0;
    sIf.instruction = 32'd0;

    // Reset state
    repeat (2) @(negedge clock);
    checkOutput("rst instr_ready", {31'd0, sIf.instr_ready}, 32'd1);
    checkOutput("rst busy", {31'd0, sIf.busy}, 32'd0);
    checkOutput("rst alu_enable", {31'd0, sIf.alu_enable}, 32'd0);
    checkOutput("rst rf_we", {31'd0, sIf.rf_we}, 32'd0);
    checkOutput("rst illegal", {31'd0, sIf.illegal}, 32'd0);
    checkOutput("rst retired", {28'd0, sIf.retired_count}, 32'd0);
    checkOutput("rst alu_instruction", sIf.alu_instruction, 32'd0);
    checkOutput("rst rf_wd", sIf.rf_wd, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // 1: single ADD x3,x1,x2
    sIf.instr_valid = 1'b1;
    sIf.instruction = ADD_X3_X1_X2;
    @(negedge clock);
    sIf.instr_valid = 1'b0;
    sIf.instruction = 32'hFFFFFFFF;
    checkOutput("t1 read instr_ready", {31'd0, sIf.instr_ready}, 32'd0);
    checkOutput("t1 read busy", {31'd0, sIf.busy}, 32'd1);
    checkOutput("t1 read rf_rs1", {27'd0, sIf.rf_rs1}, 32'd1);
    checkOutput("t1 read rf_rs2", {27'd0, sIf.rf_rs2}, 32'd2);
    checkOutput("t1 read alu_enable", {31'd0, sIf.alu_enable}, 32'd0);
    @(negedge clock);
    checkOutput("t1 exec alu_enable", {31'd0, sIf.alu_enable}, 32'd1);
    checkOutput("t1 exec rs1", sIf.alu_rs1_value, 32'd5);
    checkOutput("t1 exec rs2", sIf.alu_rs2_value, 32'd7);
    checkOutput("t1 exec alu_instruction", sIf.alu_instruction, ADD_X3_X1_X2);
    checkOutput("t1 exec rf_we", {31'd0, sIf.rf_we}, 32'd0);
    checkOutput("t1 exec instr_ready", {31'd0, sIf.instr_ready}, 32'd0);
    @(negedge clock);
    checkOutput("t1 wb rf_we", {31'd0, sIf.rf_we}, 32'd1);
    checkOutput("t1 wb rf_rd", {27'd0, sIf.rf_rd}, 32'd3);
    checkOutput("t1 wb rf_wd", sIf.rf_wd, 32'd12);
    checkOutput("t1 wb alu_enable", {31'd0, sIf.alu_enable}, 32'd0);
    checkOutput("t1 wb retired", {28'd0, sIf.retired_count}, 32'd0);
    @(negedge clock);
    checkOutput("t1 idle instr_ready", {31'd0, sIf.instr_ready}, 32'd1);
    checkOutput("t1 idle rf_we", {31'd0, sIf.rf_we}, 32'd0);
    checkOutput("t1 idle retired", {28'd0, sIf.retired_count}, 32'd1);
    checkOutput("t1 x3", rfMem[3], 32'd12);

    // 2: dependent pair with instr_valid held high
    sIf.instr_valid = 1'b1;
    sIf.instruction = ADD_X3_X1_X2;
    @(negedge clock);
    cycRead1 = cyc;
    sIf.instruction = ADD_X4_X3_X3;
    found = 1'b0;
    cycRead2 = 0;
    for (int k = 0; k < 8 && !found; k++) begin
      @(negedge clock);
      if (sIf.busy && (sIf.alu_instruction === ADD_X4_X3_X3)) begin
        found = 1'b1;
        cycRead2 = cyc;
      end
    end
    sIf.instr_valid = 1'b0;
    checkOutput("t2 second accept seen", {31'd0, found}, 32'd1);
    checkOutput("t2 accept spacing", cycRead2 - cycRead1, 32'd4);
    checkOutput("t2 read rf_rs1", {27'd0, sIf.rf_rs1}, 32'd3);
    checkOutput("t2 read rf_rs2", {27'd0, sIf.rf_rs2}, 32'd3);
    @(negedge clock);
    checkOutput("t2 exec rs1", sIf.alu_rs1_value, 32'd12);
    checkOutput("t2 exec rs2", sIf.alu_rs2_value, 32'd12);
    @(negedge clock);
    checkOutput("t2 wb rf_we", {31'd0, sIf.rf_we}, 32'd1);
    checkOutput("t2 wb rf_rd", {27'd0, sIf.rf_rd}, 32'd4);
    checkOutput("t2 wb rf_wd", sIf.rf_wd, 32'd24);
    @(negedge clock);
    checkOutput("t2 x4", rfMem[4], 32'd24);
    checkOutput("t2 retired", {28'd0, sIf.retired_count}, 32'd3);

    // 3: ADDI is rejected
    sIf.instr_valid = 1'b1;
    sIf.instruction = ADDI_NOP;
    @(negedge clock);
    sIf.instr_valid = 1'b0;
    checkOutput("t3 read illegal", {31'd0, sIf.illegal}, 32'd1);
    checkOutput("t3 read busy", {31'd0, sIf.busy}, 32'd1);
    checkOutput("t3 read alu_enable", {31'd0, sIf.alu_enable}, 32'd0);
    checkOutput("t3 read rf_we", {31'd0, sIf.rf_we}, 32'd0);
    @(negedge clock);
    checkOutput("t3 idle illegal", {31'd0, sIf.illegal}, 32'd0);
    checkOutput("t3 idle instr_ready", {31'd0, sIf.instr_ready}, 32'd1);
    checkOutput("t3 idle alu_enable", {31'd0, sIf.alu_enable}, 32'd0);
    checkOutput("t3 no capture rs1", sIf.alu_rs1_value, 32'd12);
    checkOutput("t3 retired", {28'd0, sIf.retired_count}, 32'd3);

    // 4: ADD x0 retires without writing
    sIf.instr_valid = 1'b1;
    sIf.instruction = ADD_X0_X1_X2;
    @(negedge clock);
    sIf.instr_valid = 1'b0;
    checkOutput("t4 read rf_we", {31'd0, sIf.rf_we}, 32'd0);
    @(negedge clock);
    checkOutput("t4 exec alu_enable", {31'd0, sIf.alu_enable}, 32'd1);
    checkOutput("t4 exec rf_we", {31'd0, sIf.rf_we}, 32'd0);
    @(negedge clock);
    checkOutput("t4 wb rf_we", {31'd0, sIf.rf_we}, 32'd0);
    checkOutput("t4 wb rf_rd", {27'd0, sIf.rf_rd}, 32'd0);
    checkOutput("t4 wb rf_wd", sIf.rf_wd, 32'd12);
    @(negedge clock);
    checkOutput("t4 idle instr_ready", {31'd0, sIf.instr_ready}, 32'd1);
    checkOutput("t4 retired", {28'd0, sIf.retired_count}, 32'd4);

    // 5: reset during EXEC, then a clean ADD x5
    sIf.instr_valid = 1'b1;
    sIf.instruction = ADD_X5_X1_X2;
    @(negedge clock);
    sIf.instr_valid = 1'b0;
    @(negedge clock);
    checkOutput("t5 exec alu_enable", {31'd0, sIf.alu_enable}, 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("t5 rst instr_ready", {31'd0, sIf.instr_ready}, 32'd1);
    checkOutput("t5 rst busy", {31'd0, sIf.busy}, 32'd0);
    checkOutput("t5 rst alu_enable", {31'd0, sIf.alu_enable}, 32'd0);
    checkOutput("t5 rst rf_we", {31'd0, sIf.rf_we}, 32'd0);
    checkOutput("t5 rst retired", {28'd0, sIf.retired_count}, 32'd0);
    checkOutput("t5 rst rs1", sIf.alu_rs1_value, 32'd0);
    @(negedge clock);
    checkOutput("t5 held rf_we", {31'd0, sIf.rf_we}, 32'd0);
    checkOutput("t5 held instr_ready", {31'd0, sIf.instr_ready}, 32'd1);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("t5 post rf_we", {31'd0, sIf.rf_we}, 32'd0);
    applyStimulus(ADD_X5_X1_X2);
    checkOutput("t5 x5", rfMem[5], 32'd12);
    checkOutput("t5 retired", {28'd0, sIf.retired_count}, 32'd1);

    // 6: counter wrap on the 4-bit instance
    for (int n = 0; n < 14; n++) applyStimulus(ADD_X6_X1_X2);
    checkOutput("t6 retired full", {28'd0, sIf.retired_count}, 32'd15);
    applyStimulus(ADD_X6_X1_X2);
    checkOutput("t6 retired wrap", {28'd0, sIf.retired_count}, 32'd0);
    checkOutput("t6 x6", rfMem[6], 32'd12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
